// File: rtl/muldiv_seq.sv
// Sequential radix-2 multiply/divide unit: shift-add multiply, restoring divide.
// Define MULDIV_FAST_MUL_EN to compute the four multiply ops in a single cycle.
module muldiv_seq #(
  parameter int XLEN  = 32,
  parameter int CNT_W = $clog2(XLEN) + 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [4:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            busy
);

  // Handshake: an operation transfers on a rising edge with in_valid && in_ready
  // (and no flush); a result transfers on a rising edge with out_valid && out_ready.
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]        state;
  logic [CNT_W-1:0]  cnt;
  logic [2*XLEN-1:0] acc;
  logic [XLEN-1:0]   opnd;
  logic              is_div, sel_alt, neg_res;

  // Operand decode for the operation currently offered
  logic              op_ok, op_div, a_sgn, b_sgn, neg_a, neg_b;
  logic              div_zero, div_ovf, alt_in, neg_in;
  logic [XLEN-1:0]   mag_a, mag_b;

  always_comb begin
    op_ok    = (op[4:3] == 2'b01);
    op_div   = op[2];
    a_sgn    = op_div ? ~op[0] : (op[1:0] != 2'b11);
    b_sgn    = op_div ? ~op[0] : ~op[1];
    neg_a    = a_sgn & a[XLEN-1];
    neg_b    = b_sgn & b[XLEN-1];
    mag_a    = neg_a ? -a : a;
    mag_b    = neg_b ? -b : b;
    div_zero = op_div && (b == '0);
    div_ovf  = op_div && ~op[0] && (a == {1'b1, {(XLEN-1){1'b0}}}) && (&b);
    // alt selects the high product half for MULH*, the remainder for REM*
    alt_in   = op_div ? op[1] : (op[1:0] != 2'b00);
    neg_in   = (op_div && op[1]) ? neg_a : (neg_a ^ neg_b);
  end

  // One iteration of each algorithm on the {hi, lo} accumulator
  logic [XLEN:0]     mul_sum, rem_sh, diff;
  logic [2*XLEN-1:0] acc_next;

  always_comb begin
    mul_sum = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opnd} : {(XLEN+1){1'b0}});
    rem_sh  = acc[2*XLEN-1:XLEN-1];
    diff    = rem_sh - {1'b0, opnd};
    if (!is_div)
      acc_next = {mul_sum, acc[XLEN-1:1]};
    else if (diff[XLEN])
      acc_next = {rem_sh[XLEN-1:0], acc[XLEN-2:0], 1'b0};
    else
      acc_next = {diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
  end

  function automatic logic [XLEN-1:0] finish(input logic [2*XLEN-1:0] v,
                                             input logic div, input logic alt,
                                             input logic neg);
    logic [2*XLEN-1:0] p;
    logic [XLEN-1:0]   q;
    logic [XLEN-1:0]   r;
    p = neg ? -v : v;
    q = alt ? v[2*XLEN-1:XLEN] : v[XLEN-1:0];
    if (div) r = neg ? -q : q;
    else     r = alt ? p[2*XLEN-1:XLEN] : p[XLEN-1:0];
    return r;
  endfunction

`ifdef MULDIV_FAST_MUL_EN
  logic [2*XLEN-1:0] fast_prod;
  always_comb fast_prod = {{XLEN{1'b0}}, mag_a} * {{XLEN{1'b0}}, mag_b};
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      acc     <= '0;
      opnd    <= '0;
      is_div  <= 1'b0;
      sel_alt <= 1'b0;
      neg_res <= 1'b0;
      result  <= '0;
    end else if (flush) begin
      state  <= IDLE;
      cnt    <= '0;
      result <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          cnt     <= '0;
          is_div  <= op_div;
          sel_alt <= alt_in;
          neg_res <= neg_in;
          if (!op_ok) begin
            result <= '0;
            state  <= DONE;
          end else if (div_zero) begin
            result <= op[1] ? a : {XLEN{1'b1}};
            state  <= DONE;
          end else if (div_ovf) begin
            result <= op[1] ? '0 : a;
            state  <= DONE;
`ifdef MULDIV_FAST_MUL_EN
          end else if (!op_div) begin
            result <= finish(fast_prod, 1'b0, alt_in, neg_in);
            state  <= DONE;
`endif
          end else begin
            // Divide iterates on the dividend, multiply on the multiplier
            acc   <= {{XLEN{1'b0}}, (op_div ? mag_a : mag_b)};
            opnd  <= op_div ? mag_b : mag_a;
            state <= CALC;
          end
        end
        CALC: begin
          acc <= acc_next;
          cnt <= cnt + 1'b1;
          if (cnt == CNT_W'(XLEN - 1)) begin
            result <= finish(acc_next, is_div, sel_alt, neg_res);
            state  <= DONE;
          end
        end
        DONE: if (out_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);

endmodule

// File: doc/muldiv_seq.md
MULDIV_SEQ -- requirements
Module: muldiv_seq

Interface
REQ-001 SHALL have parameter XLEN, default 32, giving the operand and result width; legal values are 8, 16, 32 and 64.
REQ-002 SHALL have parameter CNT_W, default $clog2(XLEN)+1, giving the iteration counter width.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port in_valid, input, 1 bit: an operation is offered.
REQ-006 SHALL have port in_ready, output, 1 bit: the block can accept an operation.
REQ-007 SHALL have port op, input, 5 bits: ALU operation code; 01000 MUL, 01001 MULH, 01010 MULHSU, 01011 MULHU, 01100 DIV, 01101 DIVU, 01110 REM, 01111 REMU.
REQ-008 SHALL have ports a and b, input, XLEN bits each: rs1 and rs2 operands.
REQ-009 SHALL have port flush, input, 1 bit: abort the operation in flight.
REQ-010 SHALL have port out_valid, output, 1 bit: result is available.
REQ-011 SHALL have port out_ready, input, 1 bit: the consumer takes the result.
REQ-012 SHALL have port result, output, XLEN bits: operation result.
REQ-013 SHALL have port busy, output, 1 bit: high whenever state is not IDLE; drives pipeline stall.

Function
REQ-014 SHALL implement FSM states IDLE, CALC and DONE; in_ready is 1 only in IDLE; out_valid is 1 only in DONE.
REQ-015 SHALL accept an operation on a rising edge where state=IDLE, in_valid=1 and flush=0, latching op, a and b, and clearing the counter.
REQ-016 SHALL, for a normal accept, enter CALC; each CALC cycle performs one radix-2 iteration (shift-add multiply, restoring divide) on a 2*XLEN-bit accumulator.
REQ-017 SHALL go CALC->DONE on the edge completing iteration XLEN, so out_valid rises XLEN cycles after the accept edge.
REQ-018 SHALL hold result stable in DONE until out_valid&&out_ready, then return to IDLE on that edge; no new accept occurs on that same edge.
REQ-019 SHALL handle signed operands via magnitude: negate negative inputs before iterating and correct the sign at DONE entry; MULHSU treats a as signed and b as unsigned.
REQ-020 SHALL return the low XLEN product bits for MUL and the high XLEN bits for the MULH variants.
REQ-021 SHALL on divide-by-zero (b=0) go directly IDLE->DONE: DIV/DIVU give all ones; REM/REMU give a; latency 1 cycle.
REQ-022 SHALL on signed overflow (DIV/REM, a=most-negative, b=all ones) go directly to DONE: DIV gives a, REM gives 0; latency 1 cycle.
REQ-023 SHALL treat an op outside 01000..01111 as accepted with result 0 and latency 1 cycle.
REQ-024 SHALL on flush=1 return to IDLE on the next edge from any state, drop the result, and take priority over in_valid and out_ready in the same cycle.
REQ-025 SHALL never let the counter exceed XLEN nor wrap.

Reset
REQ-026 SHALL on rst=1 immediately force state IDLE, in_ready=1, out_valid=0, busy=0, result=0 and counter=0, including mid-CALC.
REQ-027 SHALL discard any in-flight operation on reset; the first accept is possible on the first edge after rst deasserts.

Configuration
REQ-028 SHALL, when macro MULDIV_FAST_MUL_EN is defined, compute the four multiply ops with a single-cycle combinational multiplier, going IDLE->DONE at accept with 1-cycle latency; divides are unchanged.
REQ-029 SHALL, without MULDIV_FAST_MUL_EN, use the iterative multiplier of REQ-016/017 with XLEN-cycle latency.

Verification (XLEN=32, macro undefined unless noted)
REQ-030 MUL a=7, b=0xFFFFFFFD -> result 0xFFFFFFEB with out_valid 32 cycles after the accept; MULHU a=b=0xFFFFFFFF -> 0xFFFFFFFE.
REQ-031 DIV a=0xFFFFFFF9, b=2 -> 0xFFFFFFFD; REM with the same operands -> 0xFFFFFFFF; REMU a=7, b=2 -> 1.
REQ-032 DIVU a=5, b=0 -> 0xFFFFFFFF after 1 cycle; DIV a=0x80000000, b=0xFFFFFFFF -> 0x80000000; REM with the same operands -> 0.
REQ-033 out_ready held 0 for 10 cycles in DONE -> result and out_valid stable and in_ready=0; out_ready=1 -> IDLE next edge.
REQ-034 flush at iteration 15 -> IDLE next edge and no out_valid; rst pulsed mid-CALC -> all outputs at reset values immediately.
REQ-035 With MULDIV_FAST_MUL_EN defined, MULH a=0x80000000, b=2 -> 0xFFFFFFFF after 1 cycle.
